video_fx_ctrl: RTL and testbench
================================

VIDEO_FX_CTRL -- requirements
Module: video_fx_ctrl

Interface
REQ-001 Parameter INV_HOLD_FRAMES, default 2, minimum frames the inversion stays active once triggered (range 1..15).
REQ-002 clk_sys  in  1  single system clock; all logic on its rising edge.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 ce_pix  in  1  pixel clock enable; state advances only on cycles with ce_pix=1.
REQ-005 vsync  in  1  vertical sync from core, active high.
REQ-006 hblank, vblank  in  1 each  blanking from core, active high.
REQ-007 video  in  4  layer bits: [0] stars, [1] saucer, [2] rocket, [3] invert request.
REQ-008 color_req  in  1  0 monochrome, 1 colour palette; asynchronous to frame.
REQ-009 inv_en  in  1  0 forces inversion off.
REQ-010 r, g, b  out  4 each  mixed pixel colour.
REQ-011 de  out  1  data enable, pipeline-aligned with r/g/b.
REQ-012 inv  out  1  current-frame inversion flag.

Function
REQ-013 Frame boundary = vsync rising edge, detected against vsync sampled on the previous ce_pix cycle.
REQ-014 Pending flag cur_inv SHALL OR in video[3] on every ce_pix cycle.
REQ-015 At frame boundary: cur_inv=1 and inv_en=1 -> inv=1, hold counter=INV_HOLD_FRAMES-1; else hold>0 -> inv stays 1, hold decrements; else inv=0.
REQ-016 At frame boundary cur_inv SHALL clear; video[3]=1 on the boundary cycle itself counts for the new frame (cur_inv=1 after).
REQ-017 inv_en=0 SHALL clear inv, hold and cur_inv on the next ce_pix cycle, regardless of boundary.
REQ-018 color_req SHALL be latched into color_mode only at frame boundaries; no mid-frame palette change.
REQ-019 Per-layer contributions (R,G,B), zero when layer bit=0: stars (7,7,7) both modes; saucer mono (7,7,7), colour (0,15,15); rocket mono (15,15,15), colour (15,15,0).
REQ-020 Stage 1 registers the three contributions plus blank=hblank|vblank; stage 2 sums per channel at 6 bits, saturates >15 to 15, XORs all 4 bits with inv, forces 0 when blank.
REQ-021 Latency: video in -> r/g/b/de out SHALL be exactly 2 ce_pix cycles; de = ~blank delayed 2 ce_pix cycles.
REQ-022 inv used in stage 2 is the live register value (a boundary change takes effect on the next stage-2 update).
REQ-023 Outputs hold value on ce_pix=0 cycles.

Reset
REQ-024 reset_n=0 on a clock edge: r=g=b=0, de=0, inv=0, hold=0, cur_inv=0, color_mode=0, pipeline registers and vsync history =0.
REQ-025 Reset applies regardless of ce_pix; reset mid-frame discards pending inversion; first boundary after reset evaluates only post-reset video[3].

Structure
REQ-026 Shared package video_fx_pkg SHALL hold the per-layer palette constants (mono/colour, 4-bit per channel) and the 4-bit channel type.
REQ-027 One sub-module sat_mix3: three 4-bit inputs -> 4-bit saturated sum, purely combinational, instantiated once per channel.
REQ-028 Implementation SHALL be 120-400 lines RTL, no memories.

Verification
REQ-029 Mono, video=0111 steady, no blank -> after 2 ce_pix: r=g=b=15 (7+7+15 saturated), de=1.
REQ-030 color_req=1, video=0010 -> before next boundary output still (7,7,7); after boundary (0,15,15).
REQ-031 Pulse video[3] one ce_pix mid-frame, INV_HOLD_FRAMES=2 -> inv=1 for exactly 2 frames from next boundary; video=0001 gives (8,8,8), blank pixels stay 0.
REQ-032 video[3]=1 coincident with vsync rising edge, none else -> inv stays as prior rule for that boundary and becomes 1 at the following boundary.
REQ-033 inv active, inv_en dropped -> inv=0 next ce_pix; reset_n=0 mid-frame with cur_inv set -> next boundary inv=0.
REQ-034 ce_pix=1 every 4th clock, randomized video/blank -> r/g/b match scoreboard model with 2-ce latency, constant between enables.

Source files
------------

// File: rtl/video_fx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_fx_pkg
//  Description : Channel type, per-layer palette constants and layer gating
//                helper shared by the video effects controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package video_fx_pkg;

    typedef logic [3:0] chan_t;

    typedef struct packed {
        chan_t r;
        chan_t g;
        chan_t b;
    } rgb_t;

    localparam rgb_t c_black         = '{r: 4'd0,  g: 4'd0,  b: 4'd0};
    localparam rgb_t c_stars         = '{r: 4'd7,  g: 4'd7,  b: 4'd7};
    localparam rgb_t c_saucer_mono   = '{r: 4'd7,  g: 4'd7,  b: 4'd7};
    localparam rgb_t c_saucer_color  = '{r: 4'd0,  g: 4'd15, b: 4'd15};
    localparam rgb_t c_rocket_mono   = '{r: 4'd15, g: 4'd15, b: 4'd15};
    localparam rgb_t c_rocket_color  = '{r: 4'd15, g: 4'd15, b: 4'd0};

    // A layer contributes its palette entry only while its video bit is set.
    function automatic rgb_t layer_rgb(input logic en, input rgb_t val);
        return en ? val : c_black;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_mix3.sv
`default_nettype none
// ============================================================================
//  Module      : sat_mix3
//  Description : Adds three 4-bit channel contributions, saturating at 15.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_mix3
    import video_fx_pkg::*;
(
    input  chan_t i_a,
    input  chan_t i_b,
    input  chan_t i_c,
    output chan_t o_sum
);

    logic [5:0] w_sum;

    assign w_sum = {2'b00, i_a} + {2'b00, i_b} + {2'b00, i_c};
    assign o_sum = (w_sum > 6'd15) ? 4'd15 : w_sum[3:0];

endmodule
`default_nettype wire

// File: rtl/video_fx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : video_fx_ctrl
//  Description : Frame-synchronous inversion/palette control and a two-stage
//                layer mixer producing 4-bit RGB with data enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_fx_ctrl
    import video_fx_pkg::*;
#(
    parameter int INV_HOLD_FRAMES = 2
)
(
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ce_pix,
    input  logic       vsync,
    input  logic       hblank,
    input  logic       vblank,
    input  logic [3:0] video,
    input  logic       color_req,
    input  logic       inv_en,
    output logic [3:0] r,
    output logic [3:0] g,
    output logic [3:0] b,
    output logic       de,
    output logic       inv
);

    localparam logic [3:0] c_hold_init = 4'(INV_HOLD_FRAMES - 1);

    logic       r_vsync_d;
    logic       r_cur_inv;
    logic       r_inv;
    logic       r_color_mode;
    logic [3:0] r_hold;

    rgb_t       r_stars_s1;
    rgb_t       r_saucer_s1;
    rgb_t       r_rocket_s1;
    logic       r_blank_s1;

    rgb_t       r_pix;
    logic       r_de;

    logic       w_boundary;
    rgb_t       w_saucer;
    rgb_t       w_rocket;
    rgb_t       w_mix;

    assign w_boundary = vsync & ~r_vsync_d;

    // A trigger seen on the boundary cycle belongs to the new frame, so the
    // boundary decision uses the pending flag accumulated before this cycle.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_vsync_d    <= 1'b0;
            r_cur_inv    <= 1'b0;
            r_inv        <= 1'b0;
            r_hold       <= 4'd0;
            r_color_mode <= 1'b0;
        end else if (ce_pix) begin
            r_vsync_d <= vsync;
            if (w_boundary) begin
                r_color_mode <= color_req;
            end
            if (!inv_en) begin
                r_inv     <= 1'b0;
                r_hold    <= 4'd0;
                r_cur_inv <= 1'b0;
            end else if (w_boundary) begin
                r_cur_inv <= video[3];
                if (r_cur_inv) begin
                    r_inv  <= 1'b1;
                    r_hold <= c_hold_init;
                end else if (r_hold != 4'd0) begin
                    r_inv  <= 1'b1;
                    r_hold <= r_hold - 4'd1;
                end else begin
                    r_inv  <= 1'b0;
                end
            end else begin
                r_cur_inv <= r_cur_inv | video[3];
            end
        end
    end

    assign w_saucer = r_color_mode ? c_saucer_color : c_saucer_mono;
    assign w_rocket = r_color_mode ? c_rocket_color : c_rocket_mono;

    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        sat_mix3 u_mix (
            .i_a   (r_stars_s1[gi*4 +: 4]),
            .i_b   (r_saucer_s1[gi*4 +: 4]),
            .i_c   (r_rocket_s1[gi*4 +: 4]),
            .o_sum (w_mix[gi*4 +: 4])
        );
    end

    // Stage 2 uses the live inversion flag; blanking wins over inversion.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_stars_s1  <= c_black;
            r_saucer_s1 <= c_black;
            r_rocket_s1 <= c_black;
            r_blank_s1  <= 1'b0;
            r_pix       <= c_black;
            r_de        <= 1'b0;
        end else if (ce_pix) begin
            r_stars_s1  <= layer_rgb(video[0], c_stars);
            r_saucer_s1 <= layer_rgb(video[1], w_saucer);
            r_rocket_s1 <= layer_rgb(video[2], w_rocket);
            r_blank_s1  <= hblank | vblank;
            r_pix       <= r_blank_s1 ? c_black : (w_mix ^ {12{r_inv}});
            r_de        <= ~r_blank_s1;
        end
    end

    assign r   = r_pix.r;
    assign g   = r_pix.g;
    assign b   = r_pix.b;
    assign de  = r_de;
    assign inv = r_inv;

endmodule
`default_nettype wire

// File: tb/tb_video_fx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_fx_ctrl
//  Description : Self-checking bench for video_fx_ctrl: directed scenarios
//                plus randomized traffic against a frame-level reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_fx_ctrl;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce_pix = 1'b0;
    logic       vsync = 1'b0;
    logic       hblank = 1'b0;
    logic       vblank = 1'b0;
    logic [3:0] video = 4'd0;
    logic       color_req = 1'b0;
    logic       inv_en = 1'b1;
    logic [3:0] r, g, b;
    logic       de, inv;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: pixel waiting in the pipe, expected outputs, frame state.
    int m_pix[3];
    bit m_pblank;
    int e_ch[3];
    bit e_de;
    bit m_inv;
    int m_hold;
    bit m_pend;
    bit m_color;
    bit m_vs;

    video_fx_ctrl #(.INV_HOLD_FRAMES(2)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ce_pix    (ce_pix),
        .vsync     (vsync),
        .hblank    (hblank),
        .vblank    (vblank),
        .video     (video),
        .color_req (color_req),
        .inv_en    (inv_en),
        .r         (r),
        .g         (g),
        .b         (b),
        .de        (de),
        .inv       (inv)
    );

    always #5 clk_sys = ~clk_sys;

    // ch: 0 = red, 1 = green, 2 = blue
    function automatic int pix_ch(int ch, logic [3:0] v, bit color);
        int s;
        s = 0;
        if (v[0]) s += 7;
        if (v[1]) s += color ? ((ch == 0) ? 0 : 15) : 7;
        if (v[2]) s += color ? ((ch == 2) ? 0 : 15) : 15;
        return (s > 15) ? 15 : s;
    endfunction

    task automatic model_step();
        bit bnd;
        if (!reset_n) begin
            for (int c = 0; c < 3; c++) begin
                m_pix[c] = 0;
                e_ch[c] = 0;
            end
            m_pblank = 0; e_de = 0; m_inv = 0; m_hold = 0;
            m_pend = 0; m_color = 0; m_vs = 0;
            return;
        end
        if (!ce_pix) return;
        for (int c = 0; c < 3; c++)
            e_ch[c] = m_pblank ? 0 : (m_inv ? (15 - m_pix[c]) : m_pix[c]);
        e_de = !m_pblank;
        for (int c = 0; c < 3; c++) m_pix[c] = pix_ch(c, video, m_color);
        m_pblank = hblank || vblank;
        bnd = vsync && !m_vs;
        m_vs = vsync;
        if (bnd) m_color = color_req;
        if (!inv_en) begin
            m_inv = 0; m_hold = 0; m_pend = 0;
        end else if (bnd) begin
            if (m_pend) begin
                m_inv = 1; m_hold = 1;
            end else if (m_hold > 0) begin
                m_inv = 1; m_hold--;
            end else begin
                m_inv = 0;
            end
            m_pend = video[3];
        end else begin
            m_pend = m_pend || video[3];
        end
    endtask

    task automatic clk_cycle();
        model_step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) clk_cycle();
    endtask

    task automatic frame();
        vsync = 1'b1;
        clk_cycle();
        vsync = 1'b0;
        clk_cycle();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ce_pix = 1'b0;
        video = 4'b1111;
        run(3);
        n_checks++;
        if ({r, g, b} !== 12'h000) begin
            n_errors++; $display("FAIL reset_rgb: got %h want 000", {r, g, b});
        end
        n_checks++;
        if (de !== 1'b0) begin
            n_errors++; $display("FAIL reset_de: got %b want 0", de);
        end
        n_checks++;
        if (inv !== 1'b0) begin
            n_errors++; $display("FAIL reset_inv: got %b want 0", inv);
        end
    endtask

    task automatic test_mono_mix();
        reset_n = 1'b1;
        ce_pix = 1'b1;
        video = 4'b0111;
        clk_cycle();
        n_checks++;
        if (r !== 4'd0) begin
            n_errors++; $display("FAIL mono_latency1: r got %0d want 0", r);
        end
        clk_cycle();
        n_checks++;
        if ({r, g, b, de} !== {4'd15, 4'd15, 4'd15, 1'b1}) begin
            n_errors++; $display("FAIL mono_sat: got %0d %0d %0d de=%b want 15 15 15 de=1", r, g, b, de);
        end
        ce_pix = 1'b0;
        video = 4'b0000;
        run(3);
        n_checks++;
        if ({r, g, b} !== {4'd15, 4'd15, 4'd15}) begin
            n_errors++; $display("FAIL ce_hold: got %0d %0d %0d want 15 15 15", r, g, b);
        end
        ce_pix = 1'b1;
    endtask

    task automatic test_color_latch();
        color_req = 1'b1;
        video = 4'b0010;
        run(3);
        n_checks++;
        if ({r, g, b} !== {4'd7, 4'd7, 4'd7}) begin
            n_errors++; $display("FAIL color_pre_boundary: got %0d %0d %0d want 7 7 7", r, g, b);
        end
        frame();
        run(2);
        n_checks++;
        if ({r, g, b} !== {4'd0, 4'd15, 4'd15}) begin
            n_errors++; $display("FAIL color_post_boundary: got %0d %0d %0d want 0 15 15", r, g, b);
        end
    endtask

    task automatic test_inversion_hold();
        color_req = 1'b0;
        video = 4'b0001;
        frame();
        video = 4'b1001;
        clk_cycle();
        video = 4'b0001;
        run(3);
        n_checks++;
        if (inv !== 1'b0) begin
            n_errors++; $display("FAIL inv_pending_midframe: got %b want 0", inv);
        end
        frame();
        n_checks++;
        if (inv !== 1'b1) begin
            n_errors++; $display("FAIL inv_frame1: got %b want 1", inv);
        end
        run(2);
        n_checks++;
        if ({r, g, b} !== {4'd8, 4'd8, 4'd8}) begin
            n_errors++; $display("FAIL inv_pixel: got %0d %0d %0d want 8 8 8", r, g, b);
        end
        hblank = 1'b1;
        clk_cycle();
        hblank = 1'b0;
        clk_cycle();
        n_checks++;
        if ({r, g, b, de} !== 13'd0) begin
            n_errors++; $display("FAIL inv_blank: got %0d %0d %0d de=%b want 0 0 0 de=0", r, g, b, de);
        end
        frame();
        n_checks++;
        if (inv !== 1'b1) begin
            n_errors++; $display("FAIL inv_frame2: got %b want 1", inv);
        end
        frame();
        n_checks++;
        if (inv !== 1'b0) begin
            n_errors++; $display("FAIL inv_frame3: got %b want 0", inv);
        end
        run(2);
        n_checks++;
        if (r !== 4'd7) begin
            n_errors++; $display("FAIL inv_released_pixel: r got %0d want 7", r);
        end
    endtask

    task automatic test_boundary_pulse();
        vsync = 1'b1;
        video = 4'b1001;
        clk_cycle();
        vsync = 1'b0;
        video = 4'b0001;
        n_checks++;
        if (inv !== 1'b0) begin
            n_errors++; $display("FAIL bnd_pulse_same: got %b want 0", inv);
        end
        run(3);
        frame();
        n_checks++;
        if (inv !== 1'b1) begin
            n_errors++; $display("FAIL bnd_pulse_next: got %b want 1", inv);
        end
        frame();
        frame();
        n_checks++;
        if (inv !== 1'b0) begin
            n_errors++; $display("FAIL bnd_pulse_drain: got %b want 0", inv);
        end
    endtask

    task automatic test_inv_en_reset();
        video = 4'b1001;
        clk_cycle();
        video = 4'b0001;
        frame();
        n_checks++;
        if (inv !== 1'b1) begin
            n_errors++; $display("FAIL inv_en_setup: got %b want 1", inv);
        end
        inv_en = 1'b0;
        clk_cycle();
        n_checks++;
        if (inv !== 1'b0) begin
            n_errors++; $display("FAIL inv_en_drop: got %b want 0", inv);
        end
        inv_en = 1'b1;
        frame();
        n_checks++;
        if (inv !== 1'b0) begin
            n_errors++; $display("FAIL inv_en_hold_cleared: got %b want 0", inv);
        end
        video = 4'b1001;
        clk_cycle();
        video = 4'b0001;
        reset_n = 1'b0;
        ce_pix = 1'b0;
        clk_cycle();
        reset_n = 1'b1;
        ce_pix = 1'b1;
        run(3);
        frame();
        n_checks++;
        if (inv !== 1'b0) begin
            n_errors++; $display("FAIL reset_discards_pending: got %b want 0", inv);
        end
    endtask

    task automatic test_random_ce();
        reset_n = 1'b0;
        clk_cycle();
        reset_n = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            ce_pix = (i % 4 == 0);
            video = 4'($urandom_range(0, 15));
            hblank = ($urandom_range(0, 7) == 0);
            vblank = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 29) == 0) vsync = ~vsync;
            if ($urandom_range(0, 99) == 0) color_req = ~color_req;
            inv_en = ($urandom_range(0, 59) != 0);
            clk_cycle();
            n_checks++;
            if ({r, g, b, de, inv} !== {4'(e_ch[0]), 4'(e_ch[1]), 4'(e_ch[2]), e_de, m_inv}) begin
                n_errors++;
                $display("FAIL random[%0d]: got rgb=%0d,%0d,%0d de=%b inv=%b want rgb=%0d,%0d,%0d de=%b inv=%b",
                         i, r, g, b, de, inv, e_ch[0], e_ch[1], e_ch[2], e_de, m_inv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mono_mix();
        test_color_latch();
        test_inversion_hold();
        test_boundary_pulse();
        test_inv_en_reset();
        test_random_ce();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
